// File: rtl/d_cache_pkg.sv
// Shared types and helpers for the 2-way write-back data cache.
// Holds the FSM state enum, address-field width helpers and the byte-merge used on writes.
package d_cache_pkg;

  typedef enum logic [1:0] {IDLE, WBACK, REFILL, DONE} state_t;

  function automatic int off_w(input int l_words);
    return $clog2(l_words);
  endfunction

  function automatic int t_width(input int a_width, input int c_index, input int l_words);
    return a_width - c_index - off_w(l_words) - 2;
  endfunction

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  wen);
    logic [31:0] merged;
    merged = old_word;
    for (int i = 0; i < 4; i++) begin
      if (wen[i]) merged[8*i +: 8] = new_word[8*i +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/d_cache_wb_if.sv
// CPU-side and memory-side buses of the data cache bundled into one interface.
// The cache uses the slave view; the CPU/memory environment uses the master view.
interface d_cache_wb_if #(parameter int A_WIDTH = 32);

  logic [A_WIDTH-1:0] p_a;
  logic [31:0]        p_dout;
  logic               p_strobe;
  logic               p_rw;
  logic [3:0]         p_wen;
  logic               p_ready;
  logic [31:0]        p_din;

  logic [A_WIDTH-1:0] m_a;
  logic [31:0]        m_din;
  logic [31:0]        m_dout;
  logic               m_strobe;
  logic               m_rw;
  logic               m_ready;

  modport slave (
    input  p_a, p_dout, p_strobe, p_rw, p_wen,
    output p_ready, p_din,
    output m_a, m_din, m_strobe, m_rw,
    input  m_dout, m_ready
  );

  modport master (
    output p_a, p_dout, p_strobe, p_rw, p_wen,
    input  p_ready, p_din,
    input  m_a, m_din, m_strobe, m_rw,
    output m_dout, m_ready
  );

endinterface

// File: rtl/d_cache_wb_way.sv
// One way of the cache: valid/dirty bits, tag array and line data.
// Reads are combinational on index/offset; tag, status and word writes take effect at the clock edge.
module cache_way
  import d_cache_pkg::*;
#(
  parameter int C_INDEX = 6,
  parameter int L_WORDS = 4,
  parameter int OFF_W   = 2,
  parameter int T_WIDTH = 22
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [C_INDEX-1:0] index,
  input  logic [OFF_W-1:0]   offset,
  input  logic               tag_we,
  input  logic [T_WIDTH-1:0] tag_in,
  input  logic               stat_we,
  input  logic               valid_in,
  input  logic               dirty_in,
  input  logic               word_we,
  input  logic [31:0]        word_in,
  output logic               valid,
  output logic               dirty,
  output logic [T_WIDTH-1:0] tag,
  output logic [31:0]        word
);

  localparam int SETS = 1 << C_INDEX;

  logic [SETS-1:0]    valid_q;
  logic [SETS-1:0]    dirty_q;
  logic [T_WIDTH-1:0] tag_mem  [SETS];
  logic [31:0]        data_mem [SETS*L_WORDS];

  // Only the status bits are reset; tags and data are meaningless until valid is set.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (stat_we) begin
      valid_q[index] <= valid_in;
      dirty_q[index] <= dirty_in;
    end
  end

  always_ff @(posedge clk) begin
    if (tag_we)  tag_mem[index]            <= tag_in;
    if (word_we) data_mem[{index, offset}] <= word_in;
  end

  assign valid = valid_q[index];
  assign dirty = dirty_q[index];
  assign tag   = tag_mem[index];
  assign word  = data_mem[{index, offset}];

endmodule

// File: rtl/d_cache_wb.sv
// 2-way set-associative, write-back, write-allocate data cache with per-set LRU.
// Hits finish in the request cycle; misses run word-serial writeback and refill bursts.
module d_cache_wb
  import d_cache_pkg::*;
#(
  parameter int A_WIDTH = 32,
  parameter int C_INDEX = 6,
  parameter int L_WORDS = 4
) (
  input logic         clk,
  input logic         rst,
  d_cache_wb_if.slave bus
);

  localparam int OFF_W   = off_w(L_WORDS);
  localparam int T_WIDTH = t_width(A_WIDTH, C_INDEX, L_WORDS);
  localparam int SETS    = 1 << C_INDEX;
  localparam int TAG_LO  = C_INDEX + OFF_W + 2;

  state_t state_q, state_d;

  logic [T_WIDTH-1:0] lat_tag;
  logic [C_INDEX-1:0] lat_index;
  logic [OFF_W-1:0]   lat_offset;
  logic [31:0]        lat_data;
  logic               lat_rw;
  logic [3:0]         lat_wen;
  logic               victim_q;
  logic [OFF_W-1:0]   cnt_q;
  logic [SETS-1:0]    lru_q;

  logic [T_WIDTH-1:0] p_tag;
  logic [C_INDEX-1:0] p_index;
  logic [OFF_W-1:0]   p_offset;
  logic               unused_addr;

  logic               idle;
  logic [C_INDEX-1:0] index;
  logic [OFF_W-1:0]   offset;
  logic [1:0]         way_valid, way_dirty, hit_vec;
  logic [T_WIDTH-1:0] way_tag  [2];
  logic [31:0]        way_word [2];
  logic [1:0]         tag_we, stat_we, word_we;
  logic               dirty_in;
  logic [31:0]        word_in;
  logic               hit_way, req_hit, victim, last, sel_way;

  assign p_tag       = bus.p_a[A_WIDTH-1:TAG_LO];
  assign p_index     = bus.p_a[TAG_LO-1:OFF_W+2];
  assign p_offset    = bus.p_a[OFF_W+1:2];
  assign unused_addr = ^bus.p_a[1:0];

  // Outside IDLE the request may have been withdrawn, so the ways follow the latched address.
  assign idle  = (state_q == IDLE);
  assign index = idle ? p_index : lat_index;

  always_comb begin
    offset = p_offset;
    case (state_q)
      WBACK, REFILL: offset = cnt_q;
      DONE:          offset = lat_offset;
      default:       offset = p_offset;
    endcase
  end

  for (genvar w = 0; w < 2; w++) begin : g_way
    cache_way #(
      .C_INDEX(C_INDEX), .L_WORDS(L_WORDS), .OFF_W(OFF_W), .T_WIDTH(T_WIDTH)
    ) u_way (
      .clk      (clk),
      .rst      (rst),
      .index    (index),
      .offset   (offset),
      .tag_we   (tag_we[w]),
      .tag_in   (lat_tag),
      .stat_we  (stat_we[w]),
      .valid_in (1'b1),
      .dirty_in (dirty_in),
      .word_we  (word_we[w]),
      .word_in  (word_in),
      .valid    (way_valid[w]),
      .dirty    (way_dirty[w]),
      .tag      (way_tag[w]),
      .word     (way_word[w])
    );
    assign hit_vec[w] = way_valid[w] && (way_tag[w] == p_tag);
  end

  assign hit_way = ~hit_vec[0];
  assign req_hit = idle && bus.p_strobe && (|hit_vec);
  assign victim  = !way_valid[0] ? 1'b0 : (!way_valid[1] ? 1'b1 : lru_q[p_index]);
  assign last    = (cnt_q == OFF_W'(L_WORDS - 1));
  assign sel_way = idle ? hit_way : victim_q;

  // Next state, bus outputs and way write strobes for the current state.
  always_comb begin
    state_d      = state_q;
    bus.p_ready  = 1'b0;
    bus.m_strobe = 1'b0;
    bus.m_rw     = 1'b0;
    bus.m_a      = '0;
    tag_we       = '0;
    stat_we      = '0;
    word_we      = '0;
    dirty_in     = 1'b1;
    word_in      = bus.m_dout;
    case (state_q)
      IDLE: begin
        if (req_hit) begin
          bus.p_ready = 1'b1;
          if (bus.p_rw) begin
            word_we[hit_way] = 1'b1;
            stat_we[hit_way] = 1'b1;
            word_in = merge_bytes(way_word[hit_way], bus.p_dout, bus.p_wen);
          end
        end else if (bus.p_strobe) begin
          state_d = (way_valid[victim] && way_dirty[victim]) ? WBACK : REFILL;
        end
      end
      WBACK: begin
        bus.m_strobe = 1'b1;
        bus.m_rw     = 1'b1;
        bus.m_a      = {way_tag[victim_q], lat_index, cnt_q, 2'b00};
        if (bus.m_ready && last) state_d = REFILL;
      end
      REFILL: begin
        bus.m_strobe = 1'b1;
        bus.m_a      = {lat_tag, lat_index, cnt_q, 2'b00};
        if (bus.m_ready) begin
          word_we[victim_q] = 1'b1;
          if (last) begin
            tag_we[victim_q]  = 1'b1;
            stat_we[victim_q] = 1'b1;
            dirty_in          = 1'b0;
            state_d           = DONE;
          end
        end
      end
      DONE: begin
        bus.p_ready = 1'b1;
        if (lat_rw) begin
          word_we[victim_q] = 1'b1;
          stat_we[victim_q] = 1'b1;
          word_in = merge_bytes(way_word[victim_q], lat_data, lat_wen);
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.p_din = way_word[sel_way];
  assign bus.m_din = way_word[victim_q];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      lru_q    <= '0;
      victim_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (idle && bus.p_strobe && !req_hit) begin
        victim_q <= victim;
        cnt_q    <= '0;
      end
      if ((state_q == WBACK || state_q == REFILL) && bus.m_ready) begin
        cnt_q <= last ? '0 : cnt_q + 1'b1;
      end
      if (req_hit)           lru_q[p_index]   <= ~hit_way;
      if (state_q == DONE)   lru_q[lat_index] <= ~victim_q;
    end
  end

  // The miss request is captured so the CPU may drop or change its bus during the refill.
  always_ff @(posedge clk) begin
    if (idle && bus.p_strobe && !req_hit) begin
      lat_tag    <= p_tag;
      lat_index  <= p_index;
      lat_offset <= p_offset;
      lat_data   <= bus.p_dout;
      lat_rw     <= bus.p_rw;
      lat_wen    <= bus.p_wen;
    end
  end

endmodule
